arb_mux2_reg: RTL and testbench
===============================

ARB_MUX2_REG -- requirements
Module: arb_mux2_reg

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, data width of each input stream and of the output.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: in1  input  WIDTH  stream 1 data.
REQ-005 SHALL have port: in1_valid  input  1  stream 1 beat present.
REQ-006 SHALL have port: in1_ready  output  1  stream 1 beat accepted this cycle.
REQ-007 SHALL have port: in2  input  WIDTH  stream 2 data.
REQ-008 SHALL have port: in2_valid  input  1  stream 2 beat present.
REQ-009 SHALL have port: in2_ready  output  1  stream 2 beat accepted this cycle.
REQ-010 SHALL have port: out  output  WIDTH  registered selected data.
REQ-011 SHALL have port: out_valid  output  1  out holds a beat.
REQ-012 SHALL have port: out_ready  input  1  downstream accepts the beat.
REQ-013 SHALL have port: sel  output  1  source of the current out beat; 0 = in1, 1 = in2 (same encoding as the mux select).

Function
REQ-014 SHALL define load = ~out_valid | out_ready; a new beat enters the output register only when load = 1.
REQ-015 SHALL keep a round-robin priority bit prio: prio = 0 favours in1, prio = 1 favours in2.
REQ-016 SHALL grant arbitration as follows: both inputs valid -> grant the source favoured by prio; one input valid -> grant that input; neither valid -> no grant.
REQ-017 SHALL assert in1_ready = load & grant1 and in2_ready = load & grant2; the two ready outputs SHALL never be high together.
REQ-018 SHALL, on a transfer, register out = granted data, sel = granted index, out_valid = 1, and set prio to the non-granted source.
REQ-019 SHALL clear out_valid when out_ready = 1 and there is no grant.
REQ-020 SHALL hold out, sel and out_valid stable while out_valid = 1 and out_ready = 0.
REQ-021 SHALL have a latency of 1 cycle from input transfer to out_valid, and sustain 1 beat per cycle when out_ready is held high.
REQ-022 SHALL leave prio unchanged in cycles with no transfer.
REQ-023 SHALL have ready depend combinationally on out_ready and the valid inputs only; no input SHALL depend on any ready output.

Reset
REQ-024 SHALL, while rst_n = 0 at a clock edge, set out_valid = 0, out = 0, sel = 0 and prio = 0; in1_ready and in2_ready SHALL be 0 during reset.
REQ-025 SHALL discard any beat held in the output register when reset is asserted mid-stream; no beat SHALL be emitted in the first cycle after reset release.

Configuration
REQ-026 SHALL support macro ARB_MUX2_REG_PKT_LOCK_EN.
REQ-027 With ARB_MUX2_REG_PKT_LOCK_EN defined: ports in1_last, in2_last (input, 1) and out_last (output, 1, registered with out) SHALL exist; a lock flag SHALL hold the grant on the current source from the first beat until its last = 1 beat transfers, even if the other input is valid; prio SHALL update only on last beats; lock SHALL reset to 0.
REQ-028 Without the macro: these ports and the lock flag SHALL be absent, and arbitration SHALL be performed per beat as in REQ-016.

Structure
REQ-029 SHALL place shared constants SEL_IN1 = 1'b0 and SEL_IN2 = 1'b1 in the shared gates package; WIDTH SHALL remain a module parameter.
REQ-030 SHALL implement the data select with one instance of the library inverting 2:1 mux (Mux2I) driven by the grant, with its output re-inverted before the output register; no other sub-module SHALL be used.

Verification
REQ-031 After reset with in1_valid = in2_valid = 1, in1 = 0x11, in2 = 0x22 and out_ready = 1 held, out SHALL be 0x11, 0x22, 0x11, 0x22 with sel = 0, 1, 0, 1.
REQ-032 With only in2_valid = 1, in2 = 0xA5, and out_ready = 0, out_valid SHALL rise after 1 cycle with out = 0xA5 and SHALL hold for 5 stall cycles with in2_ready = 0.
REQ-033 With out_valid = 1, out_ready = 1 and both inputs invalid, out_valid SHALL be 0 in the next cycle and prio SHALL be unchanged.
REQ-034 Asserting rst_n = 0 for 1 cycle while out_valid = 1 and out = 0x3C SHALL give out_valid = 0, out = 0x00 and sel = 0 on the next edge.
REQ-035 (PKT_LOCK_EN) With in1 sending a 3-beat packet (last on beat 3) and in2 continuously valid, the output SHALL carry in1 beats 1-3 back-to-back, then in2, with out_last = 1 only on beat 3.

Source files
------------

// File: rtl/arb_mux2_reg_pkg.sv
// Shared constants for the two-input registered arbiter mux.
// SEL_IN1/SEL_IN2 encode both the mux select and the sel output.
package arb_mux2_reg_pkg;
   localparam logic SEL_IN1 = 1'b0;
   localparam logic SEL_IN2 = 1'b1;
endpackage

// File: rtl/arb_mux2_reg_mux2i.sv
// Library inverting 2:1 mux: y = ~(s ? b : a).
// Ports: a, b data in; s select (0 = a); y inverted result.
module Mux2I #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             s,
   output logic [WIDTH-1:0] y
);
   assign y = ~(s ? b : a);
endmodule

// File: rtl/arb_mux2_reg.sv
// Round-robin arbiter merging two valid/ready streams into one output
// register. Ports: clk, rst_n (sync, active-low); in1/in2 streams with
// valid/ready; out/out_valid/out_ready/sel output stream.
// Macro ARB_MUX2_REG_PKT_LOCK_EN adds in1_last/in2_last/out_last and
// holds the grant on one source until its last beat transfers.
module arb_mux2_reg
   import arb_mux2_reg_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in1,
   input  logic             in1_valid,
   output logic             in1_ready,
   input  logic [WIDTH-1:0] in2,
   input  logic             in2_valid,
   output logic             in2_ready,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             sel
`ifdef ARB_MUX2_REG_PKT_LOCK_EN
   ,
   input  logic             in1_last,
   input  logic             in2_last,
   output logic             out_last
`endif
);
   logic             prio;
   logic             load;
   logic             elig1;
   logic             elig2;
   logic             g1;
   logic             g2;
   logic             gsel;
   logic             glast;
   logic             xfer;
   logic [WIDTH-1:0] mux_n;

`ifdef ARB_MUX2_REG_PKT_LOCK_EN
   logic lock;
   // While locked, sel still names the source of the open packet.
   assign elig1 = in1_valid & (~lock | (sel == SEL_IN1));
   assign elig2 = in2_valid & (~lock | (sel == SEL_IN2));
   assign glast = g2 ? in2_last : in1_last;
`else
   assign elig1 = in1_valid;
   assign elig2 = in2_valid;
   assign glast = 1'b1;
`endif

   assign g1 = elig1 & (~elig2 | (prio == SEL_IN1));
   assign g2 = elig2 & (~elig1 | (prio == SEL_IN2));

   assign load      = ~out_valid | out_ready;
   assign in1_ready = rst_n & load & g1;
   assign in2_ready = rst_n & load & g2;
   assign xfer      = load & (g1 | g2);
   assign gsel      = g2 ? SEL_IN2 : SEL_IN1;

   Mux2I #(
      .WIDTH(WIDTH)
   ) u_mux (
      .a(in1),
      .b(in2),
      .s(gsel),
      .y(mux_n)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out       <= '0;
         out_valid <= 1'b0;
         sel       <= SEL_IN1;
         prio      <= SEL_IN1;
`ifdef ARB_MUX2_REG_PKT_LOCK_EN
         out_last  <= 1'b0;
         lock      <= 1'b0;
`endif
      end else if (xfer) begin
         // Undo the mux inversion on the way into the register.
         out       <= ~mux_n;
         out_valid <= 1'b1;
         sel       <= gsel;
         if (glast)
            prio <= ~gsel;
`ifdef ARB_MUX2_REG_PKT_LOCK_EN
         out_last  <= glast;
         lock      <= ~glast;
`endif
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_arb_mux2_reg.sv
// Self-checking bench for arb_mux2_reg: directed scenarios plus a
// randomized run against a cycle-level reference model.
module tb_arb_mux2_reg;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] in1;
   logic         in1_valid;
   logic         in1_ready;
   logic [W-1:0] in2;
   logic         in2_valid;
   logic         in2_ready;
   logic [W-1:0] out;
   logic         out_valid;
   logic         out_ready;
   logic         sel;
   logic         in1_last;
   logic         in2_last;
   logic         out_last;

   int n_cmp = 0;
   int n_bad = 0;

   // reference state: what the output register should hold
   logic         m_prio, m_v, m_s, m_lock, m_last;
   logic [W-1:0] m_d;
   logic         e_r1, e_r2;

   always #5 clk = ~clk;

   arb_mux2_reg #(
      .WIDTH(W)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in1(in1),
      .in1_valid(in1_valid),
      .in1_ready(in1_ready),
      .in2(in2),
      .in2_valid(in2_valid),
      .in2_ready(in2_ready),
      .out(out),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sel(sel)
`ifdef ARB_MUX2_REG_PKT_LOCK_EN
      ,
      .in1_last(in1_last),
      .in2_last(in2_last),
      .out_last(out_last)
`endif
   );

`ifndef ARB_MUX2_REG_PKT_LOCK_EN
   assign out_last = 1'b1;
`endif

   // Drive one cycle of inputs at negedge and advance the model to the
   // state expected after the coming rising edge.
   task automatic drive(input logic r, input logic v1,
                        input logic [W-1:0] d1, input logic t1,
                        input logic v2, input logic [W-1:0] d2,
                        input logic t2, input logic rdy);
      logic e1, e2, g1, g2, ld, gl;
      int   who;
      @(negedge clk);
      rst_n = r; in1_valid = v1; in1 = d1; in1_last = t1;
      in2_valid = v2; in2 = d2; in2_last = t2; out_ready = rdy;
      #1;
      e1 = v1 && (!m_lock || m_s == 1'b0);
      e2 = v2 && (!m_lock || m_s == 1'b1);
      who = (e1 && e2) ? (m_prio ? 2 : 1) : e1 ? 1 : e2 ? 2 : 0;
      g1 = (who == 1);
      g2 = (who == 2);
      ld = !m_v || rdy;
      e_r1 = r && ld && g1;
      e_r2 = r && ld && g2;
`ifdef ARB_MUX2_REG_PKT_LOCK_EN
      gl = g2 ? t2 : t1;
`else
      gl = 1'b1;
`endif
      if (!r) begin
         m_v = 0; m_d = 0; m_s = 0; m_prio = 0; m_lock = 0; m_last = 0;
      end else if (ld && who != 0) begin
         m_v = 1;
         m_d = g2 ? d2 : d1;
         m_s = g2;
         m_last = gl;
         if (gl) m_prio = !g2;
`ifdef ARB_MUX2_REG_PKT_LOCK_EN
         m_lock = !gl;
`endif
      end else if (rdy) begin
         m_v = 0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
   endtask

   task automatic test_reset();
      drive(0, 1, 8'h55, 1, 1, 8'h66, 1, 1);
      n_cmp++;
      if (in1_ready !== 1'b0 || in2_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_ready got %b%b want 00", in1_ready, in2_ready);
      end
      tick();
      n_cmp++;
      if (out_valid !== 1'b0 || out !== 8'h00 || sel !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_out got v=%b d=%h s=%b want 0/00/0",
                  out_valid, out, sel);
      end
   endtask

   task automatic test_alternate();
      logic [W-1:0] exp_d [4];
      exp_d[0] = 8'h11; exp_d[1] = 8'h22;
      exp_d[2] = 8'h11; exp_d[3] = 8'h22;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, 8'h11, 1, 1, 8'h22, 1, 1);
         tick();
         n_cmp++;
         if (out_valid !== 1'b1 || out !== exp_d[i] || sel !== (i % 2 == 1)) begin
            n_bad++;
            $display("FAIL alternate[%0d] got v=%b d=%h s=%b want 1/%h/%0d",
                     i, out_valid, out, sel, exp_d[i], i % 2);
         end
      end
   endtask

   task automatic test_stall();
      do_reset();
      drive(1, 0, 8'h00, 1, 1, 8'hA5, 1, 0);
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out !== 8'hA5 || sel !== 1'b1) begin
         n_bad++;
         $display("FAIL stall_first got v=%b d=%h s=%b want 1/a5/1",
                  out_valid, out, sel);
      end
      for (int i = 0; i < 5; i++) begin
         drive(1, 0, 8'h00, 1, 1, 8'hA5, 1, 0);
         n_cmp++;
         if (in2_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_ready[%0d] got %b want 0", i, in2_ready);
         end
         tick();
         n_cmp++;
         if (out_valid !== 1'b1 || out !== 8'hA5) begin
            n_bad++;
            $display("FAIL stall_hold[%0d] got v=%b d=%h want 1/a5",
                     i, out_valid, out);
         end
      end
   endtask

   task automatic test_drain();
      do_reset();
      // in1 alone: prio moves to favour in2
      drive(1, 1, 8'h33, 1, 0, 8'h00, 1, 1);
      tick();
      drive(1, 0, 8'h00, 1, 0, 8'h00, 1, 1);
      tick();
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL drain_valid got %b want 0", out_valid);
      end
      drive(1, 1, 8'h11, 1, 1, 8'h22, 1, 1);
      tick();
      n_cmp++;
      if (out !== 8'h22 || sel !== 1'b1) begin
         n_bad++;
         $display("FAIL drain_prio got d=%h s=%b want 22/1", out, sel);
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      drive(1, 1, 8'h3C, 1, 0, 8'h00, 1, 0);
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out !== 8'h3C) begin
         n_bad++;
         $display("FAIL midrst_load got v=%b d=%h want 1/3c", out_valid, out);
      end
      drive(0, 1, 8'h3C, 1, 0, 8'h00, 1, 0);
      tick();
      n_cmp++;
      if (out_valid !== 1'b0 || out !== 8'h00 || sel !== 1'b0) begin
         n_bad++;
         $display("FAIL midrst_clear got v=%b d=%h s=%b want 0/00/0",
                  out_valid, out, sel);
      end
      drive(1, 0, 8'h00, 1, 0, 8'h00, 1, 1);
      tick();
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL midrst_release got %b want 0", out_valid);
      end
   endtask

`ifdef ARB_MUX2_REG_PKT_LOCK_EN
   task automatic test_lock();
      logic [W-1:0] ed [4];
      logic         es [4];
      logic         el [4];
      ed[0] = 8'hA1; ed[1] = 8'hA2; ed[2] = 8'hA3; ed[3] = 8'hB0;
      es[0] = 0; es[1] = 0; es[2] = 0; es[3] = 1;
      el[0] = 0; el[1] = 0; el[2] = 1; el[3] = 0;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1, i < 3, ed[i], i == 2, 1, 8'hB0, 0, 1);
         tick();
         n_cmp++;
         if (out !== ed[i] || sel !== es[i] || out_last !== el[i]) begin
            n_bad++;
            $display("FAIL lock[%0d] got d=%h s=%b l=%b want %h/%b/%b",
                     i, out, sel, out_last, ed[i], es[i], el[i]);
         end
      end
   endtask
`endif

   task automatic test_random();
      logic r, v1, v2, t1, t2, rdy;
      logic [W-1:0] d1, d2;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         r   = ($urandom_range(31) != 0);
         v1  = $urandom_range(1);
         v2  = $urandom_range(1);
         t1  = ($urandom_range(2) == 0);
         t2  = ($urandom_range(2) == 0);
         rdy = ($urandom_range(3) != 0);
         d1  = W'($urandom);
         d2  = W'($urandom);
         drive(r, v1, d1, t1, v2, d2, t2, rdy);
         n_cmp++;
         if (in1_ready !== e_r1 || in2_ready !== e_r2) begin
            n_bad++;
            $display("FAIL rand_ready[%0d] got %b%b want %b%b",
                     i, in1_ready, in2_ready, e_r1, e_r2);
         end
         tick();
         n_cmp++;
         if (out_valid !== m_v || out !== m_d || sel !== m_s) begin
            n_bad++;
            $display("FAIL rand_out[%0d] got v=%b d=%h s=%b want %b/%h/%b",
                     i, out_valid, out, sel, m_v, m_d, m_s);
         end
`ifdef ARB_MUX2_REG_PKT_LOCK_EN
         n_cmp++;
         if (out_last !== m_last) begin
            n_bad++;
            $display("FAIL rand_last[%0d] got %b want %b", i, out_last, m_last);
         end
`endif
      end
   endtask

   initial begin
      m_prio = 0; m_v = 0; m_s = 0; m_lock = 0; m_last = 0; m_d = 0;
      rst_n = 0; in1 = 0; in2 = 0; in1_valid = 0; in2_valid = 0;
      in1_last = 0; in2_last = 0; out_ready = 0;
      test_reset();
      test_alternate();
      test_stall();
      test_drain();
      test_mid_reset();
`ifdef ARB_MUX2_REG_PKT_LOCK_EN
      test_lock();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
